// File: rtl/mxu_pe_db.sv
// mxu_pe_db: double-buffered MXU processing element.
// Shadow bank reloads from the weight stream while the active bank feeds the MAC.
module mxu_pe_db #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 24,
  parameter int PHASES   = 4,
  parameter int Y_W      = 8,
  parameter int Y_INDEX  = 0,
  parameter int SATURATE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_phase,
  input  logic [Y_W-1:0]            load_weight_target_y,
  input  logic [DATA_W-1:0]         load_weight,
  input  logic                      bank_swap,
  input  logic                      act_valid,
  input  logic [DATA_W-1:0]         activation,
  input  logic [ACC_W-1:0]          partial_sum,
  output logic [ACC_W-1:0]          result,
  output logic                      result_valid,
  output logic                      sat_flag,
  output logic                      phase_out,
  output logic [Y_W-1:0]            load_weight_target_y_out,
  output logic [DATA_W-1:0]         weight_out,
  output logic [DATA_W-1:0]         activation_out_bw,
  output logic                      act_valid_out_bw,
  output logic                      active_bank,
  output logic [$clog2(PHASES)-1:0] phase_idx
);

  localparam int PW = $clog2(PHASES);

  logic [DATA_W-1:0] bank [2][PHASES];
  logic [PW-1:0]     load_ptr;
  logic              swap_pending;

  logic              wrap;
  logic              swap_now;
  logic              wr_en;
  logic              wr_bank;
  logic [PW-1:0]     wr_ptr;
  logic [DATA_W-1:0] weight_sel;

  logic [ACC_W-1:0]  act_ext;
  logic [ACC_W-1:0]  wgt_ext;
  logic [ACC_W-1:0]  prod;
  logic [ACC_W-1:0]  prod_r;
  logic [ACC_W-1:0]  psum_r;
  logic              v1;
  logic [ACC_W-1:0]  sum;
  logic              ovf;
  logic [ACC_W-1:0]  sat_val;
  logic [ACC_W-1:0]  res_next;

  logic [DATA_W-1:0] bw_act [PHASES];
  logic [PHASES-1:0] bw_v;

  // A swap lands on the wrap edge; a pulse on that very edge counts too.
  assign wrap     = (phase_idx == PW'(PHASES - 1));
  assign swap_now = wrap && (swap_pending || bank_swap);
  assign wr_en    = load_phase &&
                    (load_weight_target_y == Y_W'(Y_INDEX));

  // On a swap edge the bank becoming shadow is the one active now.
  assign wr_bank  = swap_now ? active_bank : ~active_bank;
  assign wr_ptr   = swap_now ? '0 : load_ptr;

  assign weight_sel = bank[active_bank][phase_idx];

  // Operands widened to the accumulator so the low bits are the signed product.
  assign act_ext = {{(ACC_W-DATA_W){activation[DATA_W-1]}}, activation};
  assign wgt_ext = {{(ACC_W-DATA_W){weight_sel[DATA_W-1]}}, weight_sel};
  assign prod    = act_ext * wgt_ext;

  assign sum = prod_r + psum_r;
  assign ovf = (prod_r[ACC_W-1] == psum_r[ACC_W-1]) &&
               (sum[ACC_W-1] != prod_r[ACC_W-1]);

  // Clamp toward the sign both operands shared.
  assign sat_val = prod_r[ACC_W-1] ?
                   {1'b1, {(ACC_W-1){1'b0}}} :
                   {1'b0, {(ACC_W-1){1'b1}}};

  assign res_next = ((SATURATE != 0) && ovf) ? sat_val : sum;

  assign activation_out_bw = bw_act[PHASES-1];
  assign act_valid_out_bw  = bw_v[PHASES-1];

  // Free-running phase counter; PHASES is a power of two so it wraps itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_idx <= '0;
    end else begin
      phase_idx <= phase_idx + PW'(1);
    end
  end

  // Bank selection, pending swap and shadow-bank weight writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_bank  <= 1'b0;
      swap_pending <= 1'b0;
      load_ptr     <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int p = 0; p < PHASES; p++) begin
          bank[b][p] <= '0;
        end
      end
    end else begin
      if (swap_now) begin
        active_bank  <= ~active_bank;
        swap_pending <= 1'b0;
      end else if (bank_swap) begin
        swap_pending <= 1'b1;
      end
      if (wr_en) begin
        bank[wr_bank][wr_ptr] <= load_weight;
        load_ptr              <= wr_ptr + PW'(1);
      end else if (swap_now) begin
        load_ptr <= '0;
      end
    end
  end

  // Forward weight-stream passthrough.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_out                <= 1'b0;
      load_weight_target_y_out <= '0;
      weight_out               <= '0;
    end else begin
      phase_out                <= load_phase;
      load_weight_target_y_out <= load_weight_target_y;
      weight_out               <= load_weight;
    end
  end

  // MAC stage 1: product and partial sum captured together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      prod_r <= '0;
      psum_r <= '0;
    end else begin
      v1 <= act_valid;
      if (act_valid) begin
        prod_r <= prod;
        psum_r <= partial_sum;
      end
    end
  end

  // MAC stage 2: accumulate; result holds across idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result       <= '0;
      result_valid <= 1'b0;
      sat_flag     <= 1'b0;
    end else begin
      result_valid <= v1;
      sat_flag     <= v1 & ovf;
      if (v1) begin
        result <= res_next;
      end
    end
  end

  // Backward activation delay line, shifted every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bw_v <= '0;
      for (int i = 0; i < PHASES; i++) begin
        bw_act[i] <= '0;
      end
    end else begin
      bw_v      <= {bw_v[PHASES-2:0], act_valid};
      bw_act[0] <= activation;
      for (int i = 1; i < PHASES; i++) begin
        bw_act[i] <= bw_act[i-1];
      end
    end
  end

endmodule

// File: tb/tb_mxu_pe_db.sv
// tb_mxu_pe_db: random plus directed stimulus against a behavioural PE model.
// Three instances: 24-bit wrap, 16-bit saturate, 16-bit wrap.
module tb_mxu_pe_db;

  localparam int PH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_phase;
  logic [7:0]  tgt;
  logic [7:0]  load_weight;
  logic        bank_swap;
  logic        act_valid;
  logic [7:0]  activation;
  logic [23:0] partial_sum;

  logic [23:0] res_a;
  logic [15:0] res_b, res_c;
  logic        rv_a, rv_b, rv_c;
  logic        sf_a, sf_b, sf_c;
  logic        po_a, po_b, po_c;
  logic [7:0]  tg_a, tg_b, tg_c;
  logic [7:0]  wo_a, wo_b, wo_c;
  logic [7:0]  ba_a, ba_b, ba_c;
  logic        bv_a, bv_b, bv_c;
  logic        ab_a, ab_b, ab_c;
  logic [1:0]  pi_a, pi_b, pi_c;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mxu_pe_db #(.Y_INDEX(5)) dut_a (
    .clk(clk), .rst(rst), .load_phase(load_phase),
    .load_weight_target_y(tgt), .load_weight(load_weight),
    .bank_swap(bank_swap), .act_valid(act_valid),
    .activation(activation), .partial_sum(partial_sum),
    .result(res_a), .result_valid(rv_a), .sat_flag(sf_a),
    .phase_out(po_a), .load_weight_target_y_out(tg_a),
    .weight_out(wo_a), .activation_out_bw(ba_a),
    .act_valid_out_bw(bv_a), .active_bank(ab_a), .phase_idx(pi_a)
  );

  mxu_pe_db #(.ACC_W(16), .SATURATE(1), .Y_INDEX(5)) dut_b (
    .clk(clk), .rst(rst), .load_phase(load_phase),
    .load_weight_target_y(tgt), .load_weight(load_weight),
    .bank_swap(bank_swap), .act_valid(act_valid),
    .activation(activation), .partial_sum(partial_sum[15:0]),
    .result(res_b), .result_valid(rv_b), .sat_flag(sf_b),
    .phase_out(po_b), .load_weight_target_y_out(tg_b),
    .weight_out(wo_b), .activation_out_bw(ba_b),
    .act_valid_out_bw(bv_b), .active_bank(ab_b), .phase_idx(pi_b)
  );

  mxu_pe_db #(.ACC_W(16), .SATURATE(0), .Y_INDEX(5)) dut_c (
    .clk(clk), .rst(rst), .load_phase(load_phase),
    .load_weight_target_y(tgt), .load_weight(load_weight),
    .bank_swap(bank_swap), .act_valid(act_valid),
    .activation(activation), .partial_sum(partial_sum[15:0]),
    .result(res_c), .result_valid(rv_c), .sat_flag(sf_c),
    .phase_out(po_c), .load_weight_target_y_out(tg_c),
    .weight_out(wo_c), .activation_out_bw(ba_c),
    .act_valid_out_bw(bv_c), .active_bank(ab_c), .phase_idx(pi_c)
  );

  // ---------------- behavioural model ----------------
  int          m_bank [2][PH];
  int          m_phase, m_active, m_ptr;
  bit          m_pending;
  bit          s1_v;
  logic [23:0] s1_r [3];
  bit          s1_f [3];
  bit          e_v;
  logic [23:0] e_r [3];
  bit          e_f [3];
  logic        e_po;
  logic [7:0]  e_tgt, e_w, e_bwa;
  logic        e_bwv;
  logic [7:0]  q_a [$];
  logic        q_v [$];

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int p = 0; p < PH; p++) m_bank[b][p] = 0;
    m_phase = 0; m_active = 0; m_ptr = 0; m_pending = 0;
    s1_v = 0; e_v = 0;
    for (int k = 0; k < 3; k++) begin
      s1_r[k] = '0; s1_f[k] = 0; e_r[k] = '0; e_f[k] = 0;
    end
    e_po = 0; e_tgt = '0; e_w = '0; e_bwa = '0; e_bwv = 0;
    q_a = {}; q_v = {};
    for (int i = 0; i < PH - 1; i++) begin
      q_a.push_back(8'h00); q_v.push_back(1'b0);
    end
  endtask

  // True sum mapped into a w-bit accumulator, wrapped or clamped.
  task automatic calc(input longint t, input int w, input bit sat,
                      output logic [23:0] r, output bit f);
    longint mx, mn, v;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -(longint'(1) <<< (w - 1));
    v  = t;
    f  = (t > mx) || (t < mn);
    if (f && sat) v = (t > mx) ? mx : mn;
    r = 24'(v);
    if (w == 16) r = r & 24'h00FFFF;
  endtask

  // Advance the model by one clock edge using the inputs now driven.
  task automatic model_update();
    int a, w, ps24, ps16;
    longint t24, t16;
    if (rst) begin
      model_reset();
    end else begin
      a    = int'($signed(activation));
      w    = m_bank[m_active][m_phase];
      ps24 = int'($signed(partial_sum));
      ps16 = int'($signed(partial_sum[15:0]));
      e_v  = s1_v;
      if (s1_v)
        for (int k = 0; k < 3; k++) begin
          e_r[k] = s1_r[k]; e_f[k] = s1_f[k];
        end
      s1_v = act_valid;
      if (act_valid) begin
        t24 = longint'(a * w) + longint'(ps24);
        t16 = longint'(a * w) + longint'(ps16);
        calc(t24, 24, 0, s1_r[0], s1_f[0]);
        calc(t16, 16, 1, s1_r[1], s1_f[1]);
        calc(t16, 16, 0, s1_r[2], s1_f[2]);
      end
      e_po = load_phase; e_tgt = tgt; e_w = load_weight;
      q_a.push_back(activation); q_v.push_back(act_valid);
      e_bwa = q_a.pop_front(); e_bwv = q_v.pop_front();
      if (m_phase == PH - 1 && (m_pending || bank_swap)) begin
        m_active  = 1 - m_active;
        m_pending = 0;
        m_ptr     = 0;
      end else if (bank_swap) begin
        m_pending = 1;
      end
      if (load_phase && tgt == 8'd5) begin
        m_bank[1 - m_active][m_ptr] = int'($signed(load_weight));
        m_ptr = (m_ptr + 1) % PH;
      end
      m_phase = (m_phase + 1) % PH;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t",
                 nm, got, exp, $time);
    end
  endtask

  task automatic cmp_one(input string tag, input int i,
                         input logic [23:0] r, input logic rv,
                         input logic sf, input logic po,
                         input logic [7:0] tg, input logic [7:0] wo,
                         input logic [7:0] ba, input logic bv,
                         input logic ab, input logic [1:0] pi);
    chk({tag, "_result"}, 32'(r), 32'(e_r[i]));
    chk({tag, "_valid"}, 32'(rv), 32'(e_v));
    if (e_v) chk({tag, "_sat"}, 32'(sf), 32'(e_f[i]));
    chk({tag, "_phase_out"}, 32'(po), 32'(e_po));
    chk({tag, "_tgt_out"}, 32'(tg), 32'(e_tgt));
    chk({tag, "_weight_out"}, 32'(wo), 32'(e_w));
    chk({tag, "_act_bw"}, 32'(ba), 32'(e_bwa));
    chk({tag, "_valid_bw"}, 32'(bv), 32'(e_bwv));
    chk({tag, "_active_bank"}, 32'(ab), 32'(m_active));
    chk({tag, "_phase_idx"}, 32'(pi), 32'(m_phase));
  endtask

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    cmp_one("a", 0, res_a, rv_a, sf_a, po_a, tg_a, wo_a,
            ba_a, bv_a, ab_a, pi_a);
    cmp_one("b", 1, {8'h00, res_b}, rv_b, sf_b, po_b, tg_b, wo_b,
            ba_b, bv_b, ab_b, pi_b);
    cmp_one("c", 2, {8'h00, res_c}, rv_c, sf_c, po_c, tg_c, wo_c,
            ba_c, bv_c, ab_c, pi_c);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    model_update();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_in();
    load_phase = 0; tgt = '0; load_weight = '0; bank_swap = 0;
    act_valid = 0; activation = '0; partial_sum = '0;
  endtask

  task automatic to_phase0();
    idle_in();
    for (int k = 0; k < PH && m_phase != 0; k++) step();
  endtask

  task automatic load(input int tg, input int w);
    idle_in();
    load_phase = 1; tgt = 8'(tg); load_weight = 8'(w);
    step();
    idle_in();
  endtask

  task automatic do_swap();
    int old;
    old = m_active;
    idle_in();
    bank_swap = 1;
    step();
    bank_swap = 0;
    for (int k = 0; k < 2 * PH && m_active == old; k++) step();
    chk("pin_swap_active", 32'(ab_a), 32'(1 - old));
  endtask

  int          s_act [16];
  bit          s_v [16];
  bit          s_sw [16];
  logic [23:0] s_lit [16];
  int          s_ab [16];
  logic [23:0] s_ps;

  task automatic clear_seq();
    for (int i = 0; i < 16; i++) begin
      s_act[i] = 0; s_v[i] = 0; s_sw[i] = 0;
      s_lit[i] = '0; s_ab[i] = -1;
    end
  endtask

  // MAC sequence with hand-computed result pins two edges later.
  task automatic run_seq(input int n);
    for (int i = 0; i < n + 2; i++) begin
      if (i >= 2 && s_v[i-2]) begin
        chk("pin_mac_result", 32'(res_a), 32'(s_lit[i-2]));
        chk("pin_mac_valid", 32'(rv_a), 32'd1);
        chk("pin_mac_sat", 32'(sf_a), 32'd0);
      end
      if (s_ab[i] >= 0)
        chk("pin_bank_toggle", 32'(ab_a), 32'(s_ab[i]));
      idle_in();
      partial_sum = s_ps;
      if (i < n) begin
        act_valid  = s_v[i];
        activation = 8'(s_act[i]);
        bank_swap  = s_sw[i];
      end
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1;
    idle_in();
    model_reset();
    step();
    step();
    rst = 0;
    chk("pin_reset_result", 32'(res_a), 32'd0);
    chk("pin_reset_bank", 32'(ab_a), 32'd0);
    chk("pin_phase_after_rst", 32'(pi_a), 32'd0);

    // Backward delay line.
    for (int i = 0; i < PH + 4; i++) begin
      if (i >= PH) begin
        chk("pin_bw_act", 32'(ba_a), 32'(99 + i - PH));
        chk("pin_bw_valid", 32'(bv_a), 32'd1);
      end
      idle_in();
      if (i < 4) begin
        act_valid = 1; activation = 8'(99 + i);
      end
      step();
    end

    // Load 10..40 with an ignored row-6 write, swap, MAC.
    load(5, 10); load(6, 77); load(5, 20); load(5, 30); load(5, 40);
    do_swap();
    to_phase0();
    clear_seq();
    s_ps = 24'd1;
    s_act[0] = 10; s_act[1] = 20; s_act[2] = 8'hE2; s_act[3] = 0;
    for (int i = 0; i < 4; i++) s_v[i] = 1;
    s_lit[0] = 24'd101; s_lit[1] = 24'd401;
    s_lit[2] = 24'hFFFC7D; s_lit[3] = 24'd1;
    run_seq(4);

    // Double buffer: reload shadow, swap requested mid-group.
    to_phase0();
    load(5, 1); load(5, 2); load(5, 3); load(5, 4);
    clear_seq();
    s_ps = 24'd0;
    for (int i = 1; i < 8; i++) begin
      s_v[i] = 1; s_act[i] = 3;
    end
    s_sw[1] = 1;
    s_lit[1] = 24'd60; s_lit[2] = 24'd90; s_lit[3] = 24'd120;
    s_lit[4] = 24'd3; s_lit[5] = 24'd6; s_lit[6] = 24'd9;
    s_lit[7] = 24'd12;
    for (int i = 0; i < 8; i++) s_ab[i] = (i <= 3) ? 1 : 0;
    run_seq(8);

    // Saturation: -128 * -128 + 0x7FFF.
    load(5, 8'h80); load(5, 8'h80); load(5, 8'h80); load(5, 8'h80);
    do_swap();
    idle_in();
    act_valid = 1; activation = 8'h80; partial_sum = 24'h007FFF;
    step();
    idle_in();
    step();
    chk("pin_sat_b_result", 32'(res_b), 32'h7FFF);
    chk("pin_sat_b_flag", 32'(sf_b), 32'd1);
    chk("pin_sat_c_result", 32'(res_c), 32'hBFFF);
    chk("pin_sat_c_flag", 32'(sf_c), 32'd1);
    chk("pin_sat_a_result", 32'(res_a), 32'h00BFFF);
    chk("pin_sat_a_flag", 32'(sf_a), 32'd0);

    // Forward passthrough.
    idle_in();
    load_phase = 1; tgt = 8'd5; load_weight = 8'd10;
    step();
    chk("pin_fwd_phase", 32'(po_a), 32'd1);
    chk("pin_fwd_tgt", 32'(tg_a), 32'd5);
    chk("pin_fwd_weight", 32'(wo_a), 32'd10);
    load_phase = 0; tgt = 8'd6; load_weight = 8'd20;
    step();
    chk("pin_fwd_phase2", 32'(po_a), 32'd0);
    chk("pin_fwd_tgt2", 32'(tg_a), 32'd6);
    chk("pin_fwd_weight2", 32'(wo_a), 32'd20);

    // Reset with results in flight and a swap pending.
    to_phase0();
    bank_swap = 1; act_valid = 1; activation = 8'd5;
    partial_sum = 24'd9;
    step();
    bank_swap = 0;
    step();
    rst = 1;
    #1;
    chk("pin_rst_result", 32'(res_a), 32'd0);
    chk("pin_rst_valid", 32'(rv_a), 32'd0);
    chk("pin_rst_bank", 32'(ab_a), 32'd0);
    chk("pin_rst_phase", 32'(pi_a), 32'd0);
    chk("pin_rst_bw", 32'(ba_a), 32'd0);
    idle_in();
    step();
    step();
    rst = 0;
    act_valid = 1; activation = 8'd7; partial_sum = 24'd55;
    step();
    idle_in();
    step();
    chk("pin_post_rst_mac", 32'(res_a), 32'd55);
    for (int k = 0; k < PH + 1; k++) step();
    chk("pin_pending_dropped", 32'(ab_a), 32'd0);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      int r;
      rst = ($urandom_range(0, 399) == 0);
      load_phase = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 3);
      tgt = (r < 2) ? 8'd5 : (r == 2) ? 8'd6 : 8'($urandom);
      load_weight = 8'($urandom);
      bank_swap = ($urandom_range(0, 7) == 0);
      act_valid = ($urandom_range(0, 3) != 0);
      activation = 8'($urandom);
      r = $urandom_range(0, 4);
      case (r)
        0: partial_sum = 24'h7FFF00 | 24'($urandom_range(0, 255));
        1: partial_sum = 24'h800000 | 24'($urandom_range(0, 255));
        2: partial_sum = {8'($urandom),
                          16'h7F00 | 16'($urandom_range(0, 255))};
        3: partial_sum = {8'($urandom),
                          16'h8000 | 16'($urandom_range(0, 255))};
        default: partial_sum = 24'($urandom);
      endcase
      step();
    end
    rst = 0;
    idle_in();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
